// File: rtl/pong_game_controller_if.sv
// Signal bundle between the pong game controller and the ball/raket datapath,
// VGA generator and score overlay. The controller uses the slave side.
interface pong_game_controller_if;
  logic       moveStb;
  logic       startBtn;
  logic       hitPulse;
  logic       missPulse;
  logic       ballEnable;
  logic       ballLoad;
  logic [9:0] ballLoadX;
  logic [9:0] ballLoadY;
  logic       ballLoadDx;
  logic       ballLoadDy;
  logic [7:0] scoreBcd;
  logic [1:0] lives;
  logic       flash;
  logic       gameOver;
  logic [2:0] state;

  modport master (
    output moveStb, startBtn, hitPulse, missPulse,
    input  ballEnable, ballLoad, ballLoadX, ballLoadY, ballLoadDx, ballLoadDy,
    input  scoreBcd, lives, flash, gameOver, state
  );

  modport slave (
    input  moveStb, startBtn, hitPulse, missPulse,
    output ballEnable, ballLoad, ballLoadX, ballLoadY, ballLoadDx, ballLoadDy,
    output scoreBcd, lives, flash, gameOver, state
  );
endinterface

// File: rtl/pong_game_controller.sv
// Match sequencer for the ping-pong datapath: serve/play/miss/over FSM,
// BCD score, lives, and ball enable/reload generation. All outputs registered.
module pong_game_controller #(
  parameter int H_VISIBLE_AREA = 1024,
  parameter int V_VISIBLE_AREA = 768,
  parameter int SERVE_DELAY    = 64,
  parameter int MISS_FLASH     = 32,
  parameter int LIVES_INIT     = 3
) (
  input logic                    inClock,
  input logic                    reset,
  pong_game_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY - 1);
  localparam logic [7:0] MISS_END   = 8'(MISS_FLASH);
  localparam logic [1:0] LIVES_RST  = 2'(LIVES_INIT);

  state_e     state_q, state_d;
  logic       start_btn_q;
  logic [7:0] timer_q, timer_d;
  logic [7:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic       flash_q, flash_d;
  logic       load_q, load_d;
  logic       enable_q, enable_d;
  logic       over_q, over_d;
  logic       dy_q, dy_d;

  logic       start_edge;
  logic [7:0] timer_inc;

  assign start_edge = bus.startBtn & ~start_btn_q;
  assign timer_inc  = timer_q + 8'd1;

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)       return v;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    timer_d = timer_q;
    score_d = score_q;
    lives_d = lives_q;
    flash_d = flash_q;
    dy_d    = dy_q;
    load_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d = S_SERVE;
          timer_d = 8'd0;
          score_d = 8'h00;
          lives_d = LIVES_RST;
          flash_d = 1'b0;
          dy_d    = 1'b0;
          load_d  = 1'b1;
        end
      end
      S_SERVE: begin
        if (bus.moveStb) begin
          if (timer_q == SERVE_LAST) begin
            state_d = S_PLAY;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      S_PLAY: begin
        // A hit in the same cycle as a miss wins; the miss is dropped.
        if (bus.hitPulse) begin
          score_d = bcd_inc(score_q);
        end else if (bus.missPulse) begin
          state_d = S_MISS;
          lives_d = lives_q - 2'd1;
          timer_d = 8'd0;
          flash_d = 1'b1;
        end
      end
      S_MISS: begin
        if (bus.moveStb) begin
          if (timer_inc == MISS_END) begin
            timer_d = 8'd0;
            if (lives_q == 2'd0) begin
              state_d = S_OVER;
              flash_d = 1'b1;
            end else begin
              state_d = S_SERVE;
              flash_d = 1'b0;
              dy_d    = ~dy_q;
              load_d  = 1'b1;
            end
          end else begin
            timer_d = timer_inc;
            if (timer_inc[1:0] == 2'd0) flash_d = ~flash_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    enable_d = (state_d == S_PLAY);
    over_d   = (state_d == S_OVER);
  end

  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_btn_q <= 1'b0;
      timer_q     <= 8'd0;
      score_q     <= 8'h00;
      lives_q     <= LIVES_RST;
      flash_q     <= 1'b0;
      load_q      <= 1'b0;
      enable_q    <= 1'b0;
      over_q      <= 1'b0;
      dy_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      start_btn_q <= bus.startBtn;
      timer_q     <= timer_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      flash_q     <= flash_d;
      load_q      <= load_d;
      enable_q    <= enable_d;
      over_q      <= over_d;
      dy_q        <= dy_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.ballEnable = enable_q;
  assign bus.ballLoad   = load_q;
  assign bus.ballLoadX  = 10'(H_VISIBLE_AREA / 2);
  assign bus.ballLoadY  = 10'(V_VISIBLE_AREA / 2);
  assign bus.ballLoadDx = 1'b0;
  assign bus.ballLoadDy = dy_q;
  assign bus.scoreBcd   = score_q;
  assign bus.lives      = lives_q;
  assign bus.flash      = flash_q;
  assign bus.gameOver   = over_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Randomized scoreboard bench for pong_game_controller: a rule-level match model
// queues the expected output snapshot per cycle and a monitor compares it.
module tb_pong_game_controller;

  localparam int SERVE_DELAY = 64;
  localparam int MISS_FLASH  = 32;
  localparam int LIVES_INIT  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_MISS  = 3;
  localparam int M_OVER  = 4;

  logic inClock = 1'b0;
  logic reset   = 1'b0;

  pong_game_controller_if bus();

  pong_game_controller #(
    .H_VISIBLE_AREA(1024),
    .V_VISIBLE_AREA(768),
    .SERVE_DELAY   (SERVE_DELAY),
    .MISS_FLASH    (MISS_FLASH),
    .LIVES_INIT    (LIVES_INIT)
  ) dut (
    .inClock(inClock),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 inClock = ~inClock;

  int checks = 0;
  int errors = 0;
  logic [38:0] exp_q[$];

  // Match model: plain counters and an integer score.
  int m_mode, m_cnt, m_score, m_lives;
  bit m_dy, m_load, m_flash, m_prev_btn;
  bit cur_btn;

  function automatic logic [7:0] to_bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [38:0] pack_model();
    return {3'(m_mode), m_mode == M_PLAY, m_load, 10'd512, 10'd384, 1'b0, m_dy,
            to_bcd(m_score), 2'(m_lives), m_flash, m_mode == M_OVER};
  endfunction

  function automatic logic [38:0] dut_out();
    return {bus.state, bus.ballEnable, bus.ballLoad, bus.ballLoadX, bus.ballLoadY,
            bus.ballLoadDx, bus.ballLoadDy, bus.scoreBcd, bus.lives, bus.flash, bus.gameOver};
  endfunction

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h (state %0d/%0d score %h/%h lives %0d/%0d)",
               name, $time, act, exp, act[38:36], exp[38:36], act[11:4], exp[11:4],
               act[3:2], exp[3:2]);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_score = 0; m_lives = LIVES_INIT;
    m_dy = 0; m_load = 0; m_flash = 0; m_prev_btn = 0;
  endtask

  task automatic model_start();
    m_mode = M_SERVE; m_cnt = 0; m_score = 0; m_lives = LIVES_INIT;
    m_dy = 0; m_load = 1; m_flash = 0;
  endtask

  task automatic model_step(input bit btn, input bit stb, input bit hit, input bit miss);
    bit edge_seen;
    edge_seen  = btn && !m_prev_btn;
    m_prev_btn = btn;
    m_load     = 0;
    case (m_mode)
      M_IDLE, M_OVER: if (edge_seen) model_start();
      M_SERVE: if (stb) begin
        m_cnt++;
        if (m_cnt == SERVE_DELAY) begin m_mode = M_PLAY; m_cnt = 0; end
      end
      M_PLAY: begin
        if (hit) m_score = (m_score < 99) ? m_score + 1 : 99;
        else if (miss) begin m_lives--; m_mode = M_MISS; m_cnt = 0; m_flash = 1; end
      end
      M_MISS: if (stb) begin
        m_cnt++;
        if (m_cnt == MISS_FLASH) begin
          m_cnt = 0;
          if (m_lives == 0) begin m_mode = M_OVER; m_flash = 1; end
          else begin m_mode = M_SERVE; m_flash = 0; m_dy = !m_dy; m_load = 1; end
        end else if (m_cnt % 4 == 0) begin
          m_flash = !m_flash;
        end
      end
      default: ;
    endcase
  endtask

  // Called at a falling edge; the next rising edge samples these inputs.
  task automatic drive(input bit btn, input bit stb, input bit hit, input bit miss);
    bus.startBtn  = btn;
    bus.moveStb   = stb;
    bus.hitPulse  = hit;
    bus.missPulse = miss;
    model_step(btn, stb, hit, miss);
    exp_q.push_back(pack_model());
    @(negedge inClock);
  endtask

  task automatic run_random(input int n, input int p_toggle, input int p_stb,
                            input int p_hit, input int p_miss);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(99)) < p_toggle) cur_btn = !cur_btn;
      drive(cur_btn, int'($urandom_range(99)) < p_stb,
            int'($urandom_range(99)) < p_hit, int'($urandom_range(99)) < p_miss);
    end
  endtask

  task automatic wait_mode(input int target, input int budget);
    int n;
    n = 0;
    while (m_mode != target && n < budget) begin
      if (m_mode == M_IDLE || m_mode == M_OVER) cur_btn = !cur_btn;
      drive(cur_btn, 1'($urandom_range(1)), 1'b0, m_mode == M_PLAY && target == M_MISS);
      n++;
    end
    check($sformatf("reach_state_%0d", target), 39'(bus.state), 39'(target));
  endtask

  task automatic async_reset_check();
    @(posedge inClock);
    #3;
    bus.startBtn = 0; bus.moveStb = 0; bus.hitPulse = 0; bus.missPulse = 0;
    cur_btn = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_mid_miss", dut_out(), pack_model());
    @(negedge inClock);
    @(negedge inClock);
    reset = 1'b0;
  endtask

  // Monitor: one expected snapshot per rising edge, sampled just after it.
  initial begin : monitor
    logic [38:0] e;
    forever begin
      @(posedge inClock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", dut_out(), e);
      end
    end
  end

  initial begin : stimulus
    bus.startBtn = 0; bus.moveStb = 0; bus.hitPulse = 0; bus.missPulse = 0;
    cur_btn = 0;
    model_reset();
    #1 reset = 1'b1;
    #2 check("reset_state", dut_out(), pack_model());
    @(negedge inClock);
    reset = 1'b0;

    // Start held high for the whole first match: exactly one start.
    cur_btn = 1;
    run_random(700, 0, 50, 50, 0);
    check("score_saturated", 39'(bus.scoreBcd), 39'(8'h99));

    wait_mode(M_PLAY, 500);
    drive(cur_btn, 1'b0, 1'b1, 1'b1);
    run_random(1500, 0, 50, 20, 5);
    check("one_start_game_over", 39'({bus.state, bus.gameOver, bus.flash}),
          39'({3'd4, 1'b1, 1'b1}));

    // Random restarts across several matches.
    run_random(3000, 3, 50, 20, 5);

    wait_mode(M_MISS, 2000);
    async_reset_check();
    run_random(1000, 3, 50, 20, 5);

    @(posedge inClock);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
